// File: rtl/snes_mem_pkg.sv
// Shared types for the SNES cartridge SRAM sequencer: FSM states, default
// access length and the request record carried through the pending slot.
package snes_mem_pkg;

  localparam int ACCESS_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SNES_RD,
    SNES_WR,
    MCU_RD,
    MCU_WR,
    RECOVER
  } state_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  data;
    logic        wr;
  } req_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous strobe, followed by single-cycle
// rise/fall pulses. Flops reset to the strobe's idle level so reset release is quiet.
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta, r_sync, r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/snes_rom_seq.sv
// Cartridge SRAM access sequencer: turns synchronized SNES strobes and MCU
// requests into timed SRAM cycles, SNES first, MCU filling idle bus time.
module snes_rom_seq
  import snes_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SNES_RD_n,
  input  logic        SNES_WR_n,
  input  logic [23:0] ROM_ADDR,
  input  logic        ROM_HIT,
  input  logic        IS_WRITABLE,
  input  logic [7:0]  SNES_DATA_IN,
  input  logic        mcu_req,
  input  logic        mcu_write,
  input  logic [23:0] mcu_addr,
  input  logic [7:0]  mcu_wdata,
  output logic        mcu_ack,
  output logic [7:0]  mcu_rdata,
  output logic [7:0]  snes_rdata,
  output logic        snes_rdata_valid,
  output logic        snes_overrun,
  output logic [23:0] MEM_ADDR,
  output logic        MEM_CE_n,
  output logic        MEM_OE_n,
  output logic        MEM_WE_n,
  output logic [7:0]  MEM_DQ_OUT,
  output logic        MEM_DQ_OE,
  input  logic [7:0]  MEM_DQ_IN
);

  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  logic w_rd_fall, w_wr_fall, w_wr_rise, w_unused_rd_rise;

  sync_edge u_rd_sync (.i_clk(CLK), .i_rst_n(RST_N), .i_d(SNES_RD_n),
                       .o_rise(w_unused_rd_rise), .o_fall(w_rd_fall));
  sync_edge u_wr_sync (.i_clk(CLK), .i_rst_n(RST_N), .i_d(SNES_WR_n),
                       .o_rise(w_wr_rise), .o_fall(w_wr_fall));

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_pend_vld;
  req_t            r_pend;
  logic [23:0]     r_wr_addr;
  logic            r_wr_ok;
  logic            r_mcu_block;

  logic w_wr_post, w_new, w_take, w_go, w_acc_wr, w_we_next;
  req_t w_new_req, w_sel;

  // Write address/qualifier are taken on WR fall; the data is only valid by the rise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_addr <= '0;
      r_wr_ok   <= 1'b0;
    end else if (w_wr_fall) begin
      r_wr_addr <= ROM_ADDR;
      r_wr_ok   <= ROM_HIT & IS_WRITABLE;
    end
  end

  always_comb begin
    w_wr_post = w_wr_rise & r_wr_ok;
    w_new     = (w_rd_fall & ROM_HIT) | w_wr_post;
    w_new_req = '0;
    if (w_wr_post) begin
      w_new_req.addr = r_wr_addr;
      w_new_req.data = SNES_DATA_IN;
      w_new_req.wr   = 1'b1;
    end else begin
      w_new_req.addr = ROM_ADDR;
    end
    // A fresh SNES edge in IDLE bypasses the slot to hit the 3-cycle latency.
    w_take = w_new | r_pend_vld;
    w_sel  = '0;
    if (w_new) begin
      w_sel = w_new_req;
    end else if (r_pend_vld) begin
      w_sel = r_pend;
    end else begin
      w_sel.addr = mcu_addr;
      w_sel.data = mcu_wdata;
      w_sel.wr   = mcu_write;
    end
    w_go      = w_take | (mcu_req & ~r_mcu_block);
    w_acc_wr  = (r_state == SNES_WR) || (r_state == MCU_WR);
    w_we_next = w_acc_wr && (int'(r_cnt) <= ACCESS_CYCLES - 3);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_pend_vld       <= 1'b0;
      r_pend           <= '0;
      r_mcu_block      <= 1'b0;
      mcu_ack          <= 1'b0;
      mcu_rdata        <= '0;
      snes_rdata       <= '0;
      snes_rdata_valid <= 1'b0;
      snes_overrun     <= 1'b0;
      MEM_ADDR         <= '0;
      MEM_CE_n         <= 1'b1;
      MEM_OE_n         <= 1'b1;
      MEM_WE_n         <= 1'b1;
      MEM_DQ_OUT       <= '0;
      MEM_DQ_OE        <= 1'b0;
    end else begin
      mcu_ack          <= 1'b0;
      snes_rdata_valid <= 1'b0;
      if (!mcu_req) r_mcu_block <= 1'b0;
      if (w_new) begin
        r_pend     <= w_new_req;
        r_pend_vld <= 1'b1;
        if (r_pend_vld) snes_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_go) begin
            if (w_take) begin
              r_pend_vld <= 1'b0;
              r_state    <= w_sel.wr ? SNES_WR : SNES_RD;
            end else begin
              r_state    <= w_sel.wr ? MCU_WR : MCU_RD;
            end
            r_cnt     <= '0;
            MEM_ADDR  <= w_sel.addr;
            MEM_CE_n  <= 1'b0;
            MEM_OE_n  <= w_sel.wr;
            MEM_WE_n  <= 1'b1;
            MEM_DQ_OE <= w_sel.wr;
            if (w_sel.wr) MEM_DQ_OUT <= w_sel.data;
          end
        end
        SNES_RD, SNES_WR, MCU_RD, MCU_WR: begin
          if (r_cnt == LAST) begin
            r_state   <= RECOVER;
            r_cnt     <= '0;
            MEM_CE_n  <= 1'b1;
            MEM_OE_n  <= 1'b1;
            MEM_WE_n  <= 1'b1;
            MEM_DQ_OE <= 1'b0;
            if (r_state == SNES_RD) begin
              snes_rdata       <= MEM_DQ_IN;
              snes_rdata_valid <= 1'b1;
            end
            if (r_state == MCU_RD) mcu_rdata <= MEM_DQ_IN;
            if (r_state == MCU_RD || r_state == MCU_WR) begin
              mcu_ack     <= 1'b1;
              r_mcu_block <= 1'b1;
            end
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            MEM_WE_n <= ~w_we_next;
          end
        end
        RECOVER: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snes_rom_seq.sv
// Directed bench for snes_rom_seq: a negedge monitor checks every SRAM access,
// SNES read return and MCU ack against expectation queues filled by the stimulus.
module tb_snes_rom_seq;
  import snes_mem_pkg::*;

  logic        CLK, RST_N, SNES_RD_n, SNES_WR_n;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT, IS_WRITABLE;
  logic [7:0]  SNES_DATA_IN;
  logic        mcu_req, mcu_write;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_wdata;
  logic        mcu_ack;
  logic [7:0]  mcu_rdata, snes_rdata;
  logic        snes_rdata_valid, snes_overrun;
  logic [23:0] MEM_ADDR;
  logic        MEM_CE_n, MEM_OE_n, MEM_WE_n, MEM_DQ_OE;
  logic [7:0]  MEM_DQ_OUT, MEM_DQ_IN;

  snes_rom_seq #(.ACCESS_CYCLES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .SNES_RD_n(SNES_RD_n), .SNES_WR_n(SNES_WR_n),
    .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_WRITABLE(IS_WRITABLE),
    .SNES_DATA_IN(SNES_DATA_IN), .mcu_req(mcu_req), .mcu_write(mcu_write),
    .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata), .mcu_ack(mcu_ack),
    .mcu_rdata(mcu_rdata), .snes_rdata(snes_rdata), .snes_rdata_valid(snes_rdata_valid),
    .snes_overrun(snes_overrun), .MEM_ADDR(MEM_ADDR), .MEM_CE_n(MEM_CE_n),
    .MEM_OE_n(MEM_OE_n), .MEM_WE_n(MEM_WE_n), .MEM_DQ_OUT(MEM_DQ_OUT),
    .MEM_DQ_OE(MEM_DQ_OE), .MEM_DQ_IN(MEM_DQ_IN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    return (a == 24'h123456) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h11);
  endfunction
  assign MEM_DQ_IN = mem_val(MEM_ADDR);

  function automatic req_t mk(input logic [23:0] a, input logic [7:0] d, input logic w);
    req_t r;
    r.addr = a; r.data = d; r.wr = w;
    return r;
  endfunction

  int n_chk = 0, n_fail = 0;
  req_t exp_acc[$], exp_mcu[$];
  logic [7:0] exp_rd[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor state
  int   cyc = 0, last_rise = 0, last_gap = 0, ce_len = 0, n_starts = 0, n_acks = 0;
  logic prev_ce = 1'b1, in_acc = 1'b0, cur_ok = 1'b0;
  logic [7:0] we_mask = '0;
  req_t cur = '0;
  req_t m;

  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      prev_ce = 1'b1;
      in_acc  = 1'b0;
    end else begin
      if (prev_ce && !MEM_CE_n) begin
        n_starts++;
        last_gap = cyc - last_rise;
        chk("acc_expected", 32'(exp_acc.size() != 0), 32'd1);
        in_acc = 1'b1; ce_len = 0; we_mask = '0; cur_ok = 1'b0;
        if (exp_acc.size() != 0) begin
          cur = exp_acc.pop_front();
          cur_ok = 1'b1;
          chk("acc_addr", 32'(MEM_ADDR), 32'(cur.addr));
          chk("acc_kind", 32'({MEM_DQ_OE, MEM_OE_n}), 32'({cur.wr, cur.wr}));
          if (cur.wr) chk("acc_wdata", 32'(MEM_DQ_OUT), 32'(cur.data));
        end
      end
      if (!MEM_CE_n && in_acc) begin
        if (ce_len < 8) we_mask[ce_len] = ~MEM_WE_n;
        ce_len++;
        if (cur_ok && ce_len > 1) begin
          chk("acc_hold_addr", 32'(MEM_ADDR), 32'(cur.addr));
          if (cur.wr) chk("acc_hold_data", 32'(MEM_DQ_OUT), 32'(cur.data));
        end
      end
      if (!prev_ce && MEM_CE_n && in_acc) begin
        chk("acc_len", 32'(ce_len), 32'd4);
        if (cur_ok) chk("acc_we_window", 32'(we_mask), cur.wr ? 32'h06 : 32'h00);
        in_acc = 1'b0;
        last_rise = cyc;
      end
      prev_ce = MEM_CE_n;
      if (snes_rdata_valid) begin
        chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) chk("snes_rdata", 32'(snes_rdata), 32'(exp_rd.pop_front()));
      end
      if (mcu_ack) begin
        n_acks++;
        chk("ack_expected", 32'(exp_mcu.size() != 0), 32'd1);
        if (exp_mcu.size() != 0) begin
          m = exp_mcu.pop_front();
          if (!m.wr) chk("mcu_rdata", 32'(mcu_rdata), 32'(m.data));
        end
      end
    end
  end

  task automatic wait_ce_low(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (!MEM_CE_n) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic mcu_wait_ack(input int hold);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge CLK);
      if (mcu_ack) got = 1'b1;
    end
    chk("mcu_ack_seen", 32'(got), 32'd1);
    tick(hold);
    mcu_req = 1'b0;
  endtask

  task automatic snes_write(input logic [23:0] a, input logic [7:0] d, input logic w);
    ROM_ADDR = a; ROM_HIT = 1'b1; IS_WRITABLE = w; SNES_DATA_IN = d;
    SNES_WR_n = 1'b0;
    tick(4);
    SNES_WR_n = 1'b1;
    tick(5);
  endtask

  int lat, starts0, acks0;
  bit found;

  initial begin
    RST_N = 1'b0; SNES_RD_n = 1'b1; SNES_WR_n = 1'b1; ROM_ADDR = '0; ROM_HIT = 1'b0;
    IS_WRITABLE = 1'b0; SNES_DATA_IN = '0; mcu_req = 1'b0; mcu_write = 1'b0;
    mcu_addr = '0; mcu_wdata = '0;
    @(negedge CLK);
    chk("rst_strobes", 32'({MEM_CE_n, MEM_OE_n, MEM_WE_n, MEM_DQ_OE}), 32'b1110);
    chk("rst_addr", 32'(MEM_ADDR), 32'd0);
    chk("rst_data", 32'({MEM_DQ_OUT, mcu_rdata, snes_rdata}), 32'd0);
    chk("rst_flags", 32'({mcu_ack, snes_rdata_valid, snes_overrun}), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(3);

    // SNES read: latency, enables, data and one-cycle valid
    ROM_ADDR = 24'h123456; ROM_HIT = 1'b1; SNES_RD_n = 1'b0;
    exp_acc.push_back(mk(24'h123456, 8'h00, 1'b0));
    exp_rd.push_back(8'hA5);
    wait_ce_low(lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_oe_we", 32'({MEM_OE_n, MEM_WE_n}), 32'b01);
    tick(4);
    chk("rd_valid_hi", 32'(snes_rdata_valid), 32'd1);
    chk("rd_value", 32'(snes_rdata), 32'hA5);
    tick(1);
    chk("rd_valid_lo", 32'(snes_rdata_valid), 32'd0);
    SNES_RD_n = 1'b1;
    tick(4);

    // SNES write, then the same write to a read-only address
    exp_acc.push_back(mk(24'hE00010, 8'h3C, 1'b1));
    snes_write(24'hE00010, 8'h3C, 1'b1);
    tick(10);
    chk("wr_done", 32'(exp_acc.size()), 32'd0);
    starts0 = n_starts;
    snes_write(24'hE00010, 8'h3C, 1'b0);
    tick(10);
    chk("wr_blocked", 32'(n_starts), 32'(starts0));

    // SNES and MCU requests seen in the same IDLE cycle
    ROM_ADDR = 24'h012345; SNES_RD_n = 1'b0;
    exp_acc.push_back(mk(24'h012345, 8'h00, 1'b0));
    exp_acc.push_back(mk(24'hF00000, 8'h00, 1'b0));
    exp_rd.push_back(mem_val(24'h012345));
    exp_mcu.push_back(mk(24'hF00000, mem_val(24'hF00000), 1'b0));
    tick(2);
    acks0 = n_acks;
    mcu_write = 1'b0; mcu_addr = 24'hF00000; mcu_req = 1'b1;
    mcu_wait_ack(2);
    tick(6);
    chk("prio_gap", 32'(last_gap), 32'd2);
    chk("prio_one_ack", 32'(n_acks - acks0), 32'd1);
    chk("prio_done", 32'(exp_acc.size()), 32'd0);
    SNES_RD_n = 1'b1;
    tick(4);

    // SNES read arriving during an MCU write
    mcu_write = 1'b1; mcu_addr = 24'hF00020; mcu_wdata = 8'h77; mcu_req = 1'b1;
    exp_acc.push_back(mk(24'hF00020, 8'h77, 1'b1));
    exp_mcu.push_back(mk(24'hF00020, 8'h77, 1'b1));
    exp_acc.push_back(mk(24'h200000, 8'h00, 1'b0));
    exp_rd.push_back(mem_val(24'h200000));
    wait_ce_low(lat);
    chk("mcu_latency", 32'(lat), 32'd1);
    ROM_ADDR = 24'h200000; SNES_RD_n = 1'b0;
    mcu_wait_ack(0);
    tick(8);
    chk("mid_wait", 32'(last_gap <= 5), 32'd1);
    chk("mid_done", 32'(exp_acc.size()), 32'd0);
    SNES_RD_n = 1'b1;
    tick(4);

    // Two SNES reads while busy: the second replaces the first
    mcu_write = 1'b0; mcu_addr = 24'hF00100; mcu_req = 1'b1;
    exp_acc.push_back(mk(24'hF00100, 8'h00, 1'b0));
    exp_acc.push_back(mk(24'h300004, 8'h00, 1'b0));
    exp_mcu.push_back(mk(24'hF00100, mem_val(24'hF00100), 1'b0));
    exp_rd.push_back(mem_val(24'h300004));
    tick(1);
    chk("ovr_busy", 32'(MEM_CE_n), 32'd0);
    ROM_ADDR = 24'h300000; SNES_RD_n = 1'b0;
    tick(1);
    SNES_RD_n = 1'b1;
    tick(1);
    SNES_RD_n = 1'b0;
    tick(1);
    ROM_ADDR = 24'h300004;
    mcu_wait_ack(0);
    tick(10);
    chk("overrun_set", 32'(snes_overrun), 32'd1);
    chk("ovr_done", 32'(exp_acc.size()), 32'd0);
    SNES_RD_n = 1'b1;
    tick(10);
    chk("overrun_sticky", 32'(snes_overrun), 32'd1);

    // Reset while WE_n is low on an MCU write
    mcu_write = 1'b1; mcu_addr = 24'hF00040; mcu_wdata = 8'h99; mcu_req = 1'b1;
    exp_acc.push_back(mk(24'hF00040, 8'h99, 1'b1));
    acks0 = n_acks;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge CLK);
      if (!MEM_WE_n) found = 1'b1;
    end
    chk("we_seen", 32'(found), 32'd1);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_async_strobes", 32'({MEM_CE_n, MEM_OE_n, MEM_WE_n, MEM_DQ_OE}), 32'b1110);
    chk("rst_async_addr", 32'(MEM_ADDR), 32'd0);
    mcu_req = 1'b0;
    tick(2);
    RST_N = 1'b1;
    starts0 = n_starts;
    tick(15);
    chk("rst_no_ack", 32'(n_acks), 32'(acks0));
    chk("rst_no_access", 32'(n_starts), 32'(starts0));
    chk("rst_cleared", 32'({snes_overrun, mcu_rdata, snes_rdata}), 32'd0);

    chk("acc_q_empty", 32'(exp_acc.size()), 32'd0);
    chk("rd_q_empty", 32'(exp_rd.size()), 32'd0);
    chk("mcu_q_empty", 32'(exp_mcu.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snes_rom_seq.md
# snes_rom_seq

SRAM access sequencer directly downstream of the address decoder. Takes the decoded `ROM_ADDR`/`ROM_HIT`/`IS_WRITABLE` for each SNES bus cycle and turns the SNES read/write strobes into timed cycles on the cartridge SRAM. Interleaves MCU requests into idle bus time, with the SNES always taking priority. Captures read data for the SNES data driver.

## Interface
- `ACCESS_CYCLES`, default 4: CLK cycles that `MEM_CE_n` stays asserted per access; legal range ≥2.
- `CLK` in 1: system clock.
- `RST_N` in 1: asynchronous active-low reset.
- `SNES_RD_n` in 1: raw SNES read strobe (asynchronous to CLK).
- `SNES_WR_n` in 1: raw SNES write strobe (asynchronous to CLK).
- `ROM_ADDR` in 24: decoded SRAM address.
- `ROM_HIT` in 1: address maps to SRAM.
- `IS_WRITABLE` in 1: address accepts writes.
- `SNES_DATA_IN` in 8: SNES write data.
- `mcu_req` in 1: MCU request, level; held until `mcu_ack`.
- `mcu_write` in 1: 1 = write, 0 = read; stable while `mcu_req`.
- `mcu_addr` in 24: MCU address; stable while `mcu_req`.
- `mcu_wdata` in 8: MCU write data; stable while `mcu_req`.
- `mcu_ack` out 1: one-cycle pulse when the MCU access completes.
- `mcu_rdata` out 8: MCU read data; valid with `mcu_ack` and held afterwards.
- `snes_rdata` out 8: SNES read data; held until the next SNES read.
- `snes_rdata_valid` out 1: one-cycle pulse when `snes_rdata` updates.
- `snes_overrun` out 1: sticky; a SNES request was replaced before service.
- `MEM_ADDR` out 24: SRAM address.
- `MEM_CE_n` out 1: SRAM chip enable.
- `MEM_OE_n` out 1: SRAM output enable.
- `MEM_WE_n` out 1: SRAM write enable.
- `MEM_DQ_OUT` out 8: SRAM write data.
- `MEM_DQ_OE` out 1: drive `MEM_DQ_OUT` onto the bus.
- `MEM_DQ_IN` in 8: SRAM read data.

## Operation
- Both strobes pass through a 2-flop synchronizer and then an edge detector.
- SNES read request:
  - Triggered by a synchronized falling edge of `SNES_RD_n` while `ROM_HIT`=1.
  - `ROM_ADDR` is latched on that edge.
- SNES write request, two steps:
  - On the falling edge of `SNES_WR_n`, latch `ROM_ADDR` and the qualifier `ROM_HIT & IS_WRITABLE`.
  - On the rising edge, latch `SNES_DATA_IN`. If the qualifier is set, post the request; otherwise drop it silently.
- Pending SNES request is a one-deep slot. A new SNES request arriving while the slot is full replaces the old one and sets `snes_overrun`.
- States:
  - IDLE: pending SNES → SNES_RD or SNES_WR. Otherwise `mcu_req` → MCU_RD or MCU_WR.
  - SNES_RD, SNES_WR, MCU_RD, MCU_WR: run for `ACCESS_CYCLES` cycles, then go to RECOVER.
  - RECOVER: one cycle with all enables deasserted, then IDLE.
- Per-access signals:
  - Read: `CE_n`=0 and `OE_n`=0 for the whole access. `MEM_DQ_IN` is sampled on the last access cycle.
  - Write: `CE_n`=0 and `DQ_OE`=1 for the whole access. `WE_n`=0 on cycles 2..`ACCESS_CYCLES`-1 only, so the address is set up before WE falls and held after it rises.
- Priority:
  - SNES beats MCU when both are present in IDLE.
  - An MCU access in flight is never aborted. A SNES request arriving during it waits, adding at most `ACCESS_CYCLES`+1 cycles.
- Cycle counter width is `$clog2(ACCESS_CYCLES+1)`. It is cleared on state entry.

## Timing
- Reset values:
  - All `MEM_*_n` = 1, `MEM_DQ_OE`=0, `MEM_ADDR`=0, `MEM_DQ_OUT`=0.
  - `mcu_ack`=0, `mcu_rdata`=0, `snes_rdata`=0, `snes_rdata_valid`=0, `snes_overrun`=0.
  - State IDLE, pending slot empty.
- All outputs are registered.
- SNES read latency, from the raw `SNES_RD_n` fall to `MEM_CE_n` low:
  - 3 cycles from IDLE (2 sync + 1 edge/register).
  - `snes_rdata_valid` is `ACCESS_CYCLES` cycles after `CE_n` goes low.
- MCU: `mcu_ack` pulses in the cycle after the last access cycle, together with the RECOVER cycle.
  - `mcu_req` still high in that cycle must not start a second access.
  - A new access starts only on a fresh `mcu_req` observed in IDLE.
- Reset mid-access: outputs return to their reset values asynchronously. Pending requests are lost and no ack is issued.

## Structure
- Package `snes_mem_pkg` holds:
  - the state enum (IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR, RECOVER);
  - the default `ACCESS_CYCLES`;
  - the request record (address, data, write flag).
- Sub-module `sync_edge` (2-flop sync plus rise/fall pulses, asynchronous active-low reset) is instantiated once per strobe.

## Test plan
- SNES read: `RD_n` falls with `ROM_ADDR`=0x123456 and `ROM_HIT`=1 → `CE_n`/`OE_n` low 3 cycles later for 4 cycles with `MEM_ADDR`=0x123456. `MEM_DQ_IN`=0xA5 gives `snes_rdata`=0xA5 and a one-cycle `snes_rdata_valid`.
- SNES write: `IS_WRITABLE`=1, address 0xE00010, data 0x3C → one 4-cycle write with `WE_n` low exactly 2 cycles and `MEM_DQ_OUT`=0x3C. The same write with `IS_WRITABLE`=0 → no `CE_n` activity.
- Priority: `mcu_req` (read 0xF00000) and a SNES read edge in the same IDLE cycle → the SNES access first, one RECOVER cycle, then the MCU access. `mcu_ack` pulses once.
- SNES read arriving mid-MCU-write → the MCU write completes unmodified, and `CE_n` for the SNES read falls within 5 cycles of the MCU write ending.
- Two SNES reads arriving while the sequencer is busy → only the second address is accessed and `snes_overrun`=1 until reset.
- Assert `RST_N` during a write with `WE_n` low → `WE_n`/`CE_n` go to 1 immediately, with no `mcu_ack` and no later access.
